// File: rtl/uart_pkg.sv
// Shared types and constants for the transmit-side UART: FSM state encoding,
// bit-period divisor helper and the bus-visible register offsets.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int unsigned REG_DATA_OFS = 0;
  localparam int unsigned REG_LSR_OFS  = 5;
  localparam int unsigned LSR_THRE_BIT = 5;

  // Round-to-nearest clock cycles per line bit.
  function automatic int unsigned baud_div(input int unsigned clk, input int unsigned baud);
    return (clk + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and wrap-bit pointers, so the
// occupancy count spans 0..DEPTH. DEPTH must be a power of two, at least 2.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             do_wr, do_rd;

  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    count     = wr_ptr_q - rd_ptr_q;
    // A pop cannot make room for a same-cycle push: full blocks the write outright.
    do_wr     = wr_en && !full;
    do_rd     = rd_en && !empty;
    wr_ptr_d  = do_wr ? wr_ptr_q + (AW + 1)'(1) : wr_ptr_q;
    rd_ptr_d  = do_rd ? rd_ptr_q + (AW + 1)'(1) : rd_ptr_q;
    rd_data_d = do_rd ? mem_q[rd_ptr_q[AW-1:0]] : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter, 8N1 by default; defining UART_TX_PARITY_EN
// inserts an even-parity bit (8E1).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk_50M,
  input  logic                          reset_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          txd,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_done
);

  localparam int unsigned   DIV      = baud_div(CLK_FREQ, BAUD);
  localparam int unsigned   CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DIV - 1);

  tx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          tx_done_q, tx_done_d;
  logic          line_busy_q, line_busy_d;
`ifdef UART_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif

  logic          fifo_rd_en;
  logic [7:0]    fifo_rd_data;
  logic          fifo_full, fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_50M),
    .reset_n (reset_n),
    .wr_en   (tx_valid),
    .wr_data (tx_data),
    .rd_en   (fifo_rd_en),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    fifo_rd_en = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          cnt_d      = CNT_LOAD;
          state_d    = START;
        end
      end
      START: begin
        // The popped byte lands in the FIFO's read register one cycle after the
        // pop, so it is latched at the end of the start bit rather than on entry.
        if (cnt_q == '0) begin
          cnt_d     = CNT_LOAD;
          bit_idx_d = '0;
          shift_d   = fifo_rd_data;
`ifdef UART_TX_PARITY_EN
          parity_d  = ^fifo_rd_data;
`endif
          state_d   = DATA;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_LOAD;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_LOAD;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`endif
      STOP: begin
        if (cnt_q == '0) begin
          if (!fifo_empty) begin
            fifo_rd_en = 1'b1;
            cnt_d      = CNT_LOAD;
            state_d    = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line outputs are registered from the current state, so txd, tx_done and the
  // line-busy flag trail the FSM by exactly one cycle; bit widths are unaffected.
  always_comb begin
    case (state_q)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_d = parity_q;
`endif
      default: txd_d = 1'b1;
    endcase
    tx_done_d   = (state_q == STOP) && (cnt_q == '0);
    line_busy_d = (state_q != IDLE);
  end

  always_ff @(posedge clk_50M) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      txd_q       <= 1'b1;
      tx_done_q   <= 1'b0;
      line_busy_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      txd_q       <= txd_d;
      tx_done_q   <= tx_done_d;
      line_busy_q <= line_busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign txd      = txd_q;
  assign tx_done  = tx_done_q;
  assign tx_ready = !fifo_full;
  assign tx_busy  = line_busy_q || !fifo_empty;

endmodule
